// File: rtl/spi_bridge_pkg.sv
// Shared types and field offsets for the SPI-shadow-register-to-bus debug bridge.
// Field positions that depend on parameters are computed by the helper functions.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RD_WAIT,
    ST_NEXT
  } state_e;

  localparam int CMD_CPU_RST  = 0;
  localparam int CMD_SYS_RST  = 1;
  localparam int CMD_START    = 2;
  localparam int CMD_WRITE    = 3;
  localparam int CMD_AUTO_INC = 4;
  localparam int CMD_CLR      = 5;
  localparam int CMD_LEN      = 8;

  localparam int STAT_CPU_RST  = 0;
  localparam int STAT_SYS_RST  = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_DONE     = 3;
  localparam int STAT_OVERRUN  = 4;
  localparam int STAT_HALT_ERR = 5;
  localparam int STAT_BEATS    = 8;

  function automatic int cmd_w(input int addr_w, input int data_w, input int burst_w);
    return 8 + 2 * burst_w + data_w + addr_w;
  endfunction

  function automatic int cmd_sel_lo(input int burst_w);
    return 8 + burst_w;
  endfunction

  function automatic int cmd_wdata_lo(input int burst_w);
    return 8 + 2 * burst_w;
  endfunction

  function automatic int cmd_addr_lo(input int burst_w, input int data_w);
    return 8 + 2 * burst_w + data_w;
  endfunction

  function automatic int stat_w(input int data_w, input int burst_w);
    return 8 + burst_w + data_w;
  endfunction

  function automatic int stat_data_lo(input int burst_w);
    return 8 + burst_w;
  endfunction

endpackage

// File: rtl/spi_bridge_seq.sv
// Burst sequencer: walks ACCESS/RD_WAIT/NEXT for each beat, owns the beat,
// address and read-latency counters, and flags when read data must be captured.
module spi_bridge_seq
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int BURST_W = 4,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               write_i,
  input  logic               auto_inc_i,
  input  logic [BURST_W-1:0] len_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [ADDR_W-1:0]  address_o,
  output logic [DATA_W-1:0]  wr_data_o,
  output logic               wr_en_o,
  output logic               rd_en_o,
  output logic               busy_o,
  output logic [BURST_W-1:0] beat_o,
  output logic               cap_en_o,
  output logic               done_set_o
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [2:0]         lat_q, lat_d;
  logic               write_q, write_d;
  logic               auto_q, auto_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      write_q <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      write_q <= write_d;
      auto_q  <= auto_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    write_d    = write_q;
    auto_d     = auto_q;
    cap_en_o   = 1'b0;
    done_set_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          len_d   = len_i;
          write_d = write_i;
          auto_d  = auto_inc_i;
          beat_d  = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        lat_d   = '0;
        state_d = write_q ? ST_NEXT : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Data is valid RD_LAT cycles after the strobe; capture on the last wait cycle.
        if (lat_q == LAT_LAST) begin
          cap_en_o = 1'b1;
          state_d  = ST_NEXT;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_NEXT: begin
        if (beat_q == len_q) begin
          done_set_o = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          beat_d = beat_q + BURST_W'(1);
          if (auto_q) addr_d = addr_q + ADDR_W'(1);
          state_d = ST_ACCESS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign address_o = addr_q;
  assign wr_data_o = wdata_q;
  assign wr_en_o   = (state_q == ST_ACCESS) && write_q;
  assign rd_en_o   = (state_q == ST_ACCESS) && !write_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign beat_o    = beat_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// Debug bridge from the SPI shadow command word to the Open8 CPU-side bus:
// edge detection, sticky flags, burst read buffer and registered status word.
module spi_bus_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int BURST_W      = 4,
  parameter int RD_LAT       = 1,
  parameter int REQUIRE_HALT = 1
) (
  input  logic                                      clk,
  input  logic                                      spi_reset,
  input  logic [cmd_w(ADDR_W, DATA_W, BURST_W)-1:0] cmd_word,
  output logic [stat_w(DATA_W, BURST_W)-1:0]        stat_word,
  output logic [ADDR_W-1:0]                         o_Address,
  output logic [DATA_W-1:0]                         o_Wr_Data,
  output logic                                      o_Wr_En,
  output logic                                      o_Rd_En,
  input  logic [DATA_W-1:0]                         i_Rd_Data,
  output logic                                      cpu_reset,
  output logic                                      system_reset
);

  localparam int DEPTH    = 2 ** BURST_W;
  localparam int SEL_LO   = cmd_sel_lo(BURST_W);
  localparam int WDATA_LO = cmd_wdata_lo(BURST_W);
  localparam int ADDR_LO  = cmd_addr_lo(BURST_W, DATA_W);
  localparam int STAT_W   = stat_w(DATA_W, BURST_W);
  localparam int RDATA_LO = stat_data_lo(BURST_W);

  logic               cpu_rst_bit, sys_rst_bit, start_bit, write_bit, auto_bit, clr_bit;
  logic [BURST_W-1:0] cmd_len, cmd_sel;
  logic [DATA_W-1:0]  cmd_wdata;
  logic [ADDR_W-1:0]  cmd_addr;
  logic               cmd_rsvd_unused;

  assign cpu_rst_bit     = cmd_word[CMD_CPU_RST];
  assign sys_rst_bit     = cmd_word[CMD_SYS_RST];
  assign start_bit       = cmd_word[CMD_START];
  assign write_bit       = cmd_word[CMD_WRITE];
  assign auto_bit        = cmd_word[CMD_AUTO_INC];
  assign clr_bit         = cmd_word[CMD_CLR];
  assign cmd_rsvd_unused = ^cmd_word[7:6];
  assign cmd_len         = cmd_word[CMD_LEN +: BURST_W];
  assign cmd_sel         = cmd_word[SEL_LO +: BURST_W];
  assign cmd_wdata       = cmd_word[WDATA_LO +: DATA_W];
  assign cmd_addr        = cmd_word[ADDR_LO +: ADDR_W];

  assign cpu_reset    = cpu_rst_bit;
  assign system_reset = sys_rst_bit;

  logic               start_prev_q, start_prev_d;
  logic               clr_prev_q, clr_prev_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               halt_q, halt_d;
  logic [DATA_W-1:0]  rd_buf_q [DEPTH];
  logic [DATA_W-1:0]  rd_buf_d [DEPTH];
  logic [STAT_W-1:0]  stat_q, stat_d;

  logic               start_edge, clr_edge, halt_block;
  logic               start_acc, halt_set, ovr_set;
  logic               busy, cap_en, done_set;
  logic [BURST_W-1:0] beat;

  assign start_edge = start_bit && !start_prev_q;
  assign clr_edge   = clr_bit && !clr_prev_q;
  assign halt_block = (REQUIRE_HALT != 0) && !cpu_rst_bit;
  assign start_acc  = start_edge && !busy && !halt_block;
  assign halt_set   = start_edge && !busy && halt_block;
  assign ovr_set    = start_edge && busy;

  spi_bridge_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BURST_W(BURST_W),
    .RD_LAT (RD_LAT)
  ) u_seq (
    .clk       (clk),
    .rst_n     (spi_reset),
    .start_i   (start_acc),
    .write_i   (write_bit),
    .auto_inc_i(auto_bit),
    .len_i     (cmd_len),
    .addr_i    (cmd_addr),
    .wdata_i   (cmd_wdata),
    .address_o (o_Address),
    .wr_data_o (o_Wr_Data),
    .wr_en_o   (o_Wr_En),
    .rd_en_o   (o_Rd_En),
    .busy_o    (busy),
    .beat_o    (beat),
    .cap_en_o  (cap_en),
    .done_set_o(done_set)
  );

  always_ff @(posedge clk or negedge spi_reset) begin
    if (!spi_reset) begin
      // Edge registers come up high so a bit already set at release does not fire.
      start_prev_q <= 1'b1;
      clr_prev_q   <= 1'b1;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      halt_q       <= 1'b0;
      rd_buf_q     <= '{default: '0};
      stat_q       <= '0;
    end else begin
      start_prev_q <= start_prev_d;
      clr_prev_q   <= clr_prev_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      halt_q       <= halt_d;
      rd_buf_q     <= rd_buf_d;
      stat_q       <= stat_d;
    end
  end

  always_comb begin
    start_prev_d = start_bit;
    clr_prev_d   = clr_bit;
    // Clear first, then set: a flag-setting event in the same cycle wins.
    done_d    = (clr_edge || start_acc) ? 1'b0 : done_q;
    overrun_d = clr_edge ? 1'b0 : overrun_q;
    halt_d    = clr_edge ? 1'b0 : halt_q;
    if (done_set) done_d    = 1'b1;
    if (ovr_set)  overrun_d = 1'b1;
    if (halt_set) halt_d    = 1'b1;
  end

  always_comb begin
    rd_buf_d = rd_buf_q;
    if (cap_en) rd_buf_d[beat] = i_Rd_Data;
  end

  always_comb begin
    stat_d                         = '0;
    stat_d[STAT_CPU_RST]           = cpu_rst_bit;
    stat_d[STAT_SYS_RST]           = sys_rst_bit;
    stat_d[STAT_BUSY]              = busy;
    stat_d[STAT_DONE]              = done_q;
    stat_d[STAT_OVERRUN]           = overrun_q;
    stat_d[STAT_HALT_ERR]          = halt_q;
    stat_d[STAT_BEATS +: BURST_W]  = beat;
    stat_d[RDATA_LO +: DATA_W]     = rd_buf_q[cmd_sel];
  end

  assign stat_word = stat_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Self-checking bench for spi_bus_bridge: table of directed bursts, flag and
// reset corner sequences, then random bursts checked against a transaction model.
module tb_spi_bus_bridge;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int RL = 2;
  localparam int CW = 8 + 2 * BW + DW + AW;
  localparam int SW = 8 + BW + DW;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          spi_reset;
  logic          c_cpu, c_sys, c_start, c_wr, c_auto, c_clr;
  logic [BW-1:0] c_len, c_sel;
  logic [DW-1:0] c_wdata;
  logic [AW-1:0] c_addr;
  logic [CW-1:0] cmd_word;
  logic [SW-1:0] stat_word;
  logic [AW-1:0] o_Address;
  logic [DW-1:0] o_Wr_Data;
  logic          o_Wr_En, o_Rd_En;
  logic [DW-1:0] i_Rd_Data;
  logic          cpu_reset, system_reset;

  assign cmd_word = {c_addr, c_wdata, c_sel, c_len, 2'b00, c_clr, c_auto, c_wr, c_start, c_sys, c_cpu};

  spi_bus_bridge #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BURST_W     (BW),
    .RD_LAT      (RL),
    .REQUIRE_HALT(1)
  ) dut (
    .clk         (clk),
    .spi_reset   (spi_reset),
    .cmd_word    (cmd_word),
    .stat_word   (stat_word),
    .o_Address   (o_Address),
    .o_Wr_Data   (o_Wr_Data),
    .o_Wr_En     (o_Wr_En),
    .o_Rd_En     (o_Rd_En),
    .i_Rd_Data   (i_Rd_Data),
    .cpu_reset   (cpu_reset),
    .system_reset(system_reset)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave: returns address low byte (xor a pattern) exactly RL cycles after the strobe.
  logic [7:0] rd_xor;
  logic [7:0] p1, p2;
  logic       v1, v2;
  always @(posedge clk) begin
    v1 <= o_Rd_En;
    p1 <= o_Address[7:0] ^ rd_xor;
    v2 <= v1;
    p2 <= p1;
  end
  assign i_Rd_Data = v2 ? p2 : 8'hEE;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
  } strobe_t;
  strobe_t mon_q[$];

  always @(negedge clk)
    if (spi_reset && (o_Wr_En || o_Rd_En))
      mon_q.push_back('{cyc: cyc, wr: o_Wr_En, a: o_Address, d: o_Wr_Data});

  logic [7:0] mdl_buf[16];
  int vecs = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] beat_addr(input logic [15:0] base, input int i, input bit au);
    return au ? 16'(base + i) : base;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (stat_word[2] && n < 300) begin
      tick(1);
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
  endtask

  task automatic run_cmd(input bit wr, input bit au, input logic [3:0] len, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] xr, input bit with_clr);
    int t0, per, nexp;
    logic [15:0] ea;
    c_cpu = 1'b1; c_wr = wr; c_auto = au; c_len = len; c_addr = addr; c_wdata = wd;
    rd_xor = xr; c_start = 1'b0; c_clr = 1'b0;
    tick(1);
    mon_q.delete();
    c_start = 1'b1; c_clr = with_clr; t0 = cyc;
    tick(3);
    wait_idle("burst_timeout");
    tick(1);
    c_start = 1'b0; c_clr = 1'b0;
    nexp = int'(len) + 1;
    per  = wr ? 2 : 2 + RL;
    check("strobe_count", 32'(mon_q.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < mon_q.size(); i++) begin
      ea = beat_addr(addr, i, au);
      check("strobe_addr", 32'(mon_q[i].a), 32'(ea));
      check("strobe_kind", 32'(mon_q[i].wr), 32'(wr));
      if (wr) check("strobe_wdata", 32'(mon_q[i].d), 32'(wd));
      check("strobe_cycle", 32'(mon_q[i].cyc), 32'((i == 0) ? t0 + 1 : mon_q[i-1].cyc + per));
    end
    if (!wr)
      for (int i = 0; i < nexp; i++) begin
        ea = beat_addr(addr, i, au);
        mdl_buf[i] = ea[7:0] ^ xr;
      end
    check("stat_flags", 32'(stat_word[5:0]), 32'h09);
    check("stat_beats", 32'(stat_word[11:8]), 32'(len));
    if (!wr)
      for (int s = 0; s < 16; s++) begin
        c_sel = 4'(s);
        tick(1);
        check("rd_buf", 32'(stat_word[19:12]), 32'(mdl_buf[s]));
      end
  endtask

  typedef struct {
    bit          wr;
    bit          au;
    logic [3:0]  len;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  xr;
    logic [15:0] e_first;
    logic [15:0] e_last;
    logic [3:0]  e_beats;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd0,  16'h1000, 8'hA5, 8'h00, 16'h1000, 16'h1000, 4'd0};
    tbl[1] = '{1'b0, 1'b1, 4'd3,  16'h2000, 8'h00, 8'h00, 16'h2000, 16'h2003, 4'd3};
    tbl[2] = '{1'b1, 1'b1, 4'd1,  16'hFFFF, 8'h3C, 8'h00, 16'hFFFF, 16'h0000, 4'd1};
    tbl[3] = '{1'b1, 1'b0, 4'd1,  16'hFFFF, 8'h5A, 8'h00, 16'hFFFF, 16'hFFFF, 4'd1};
    tbl[4] = '{1'b0, 1'b1, 4'd15, 16'h00F8, 8'h00, 8'h5C, 16'h00F8, 16'h0107, 4'd15};
    tbl[5] = '{1'b0, 1'b0, 4'd2,  16'h1234, 8'h00, 8'h81, 16'h1234, 16'h1234, 4'd2};
    for (int i = 0; i < 16; i++) mdl_buf[i] = 8'h00;

    spi_reset = 1'b0; rd_xor = 8'h00;
    c_cpu = 1'b1; c_sys = 1'b0; c_start = 1'b1; c_wr = 1'b1; c_auto = 1'b0; c_clr = 1'b1;
    c_len = '0; c_sel = '0; c_wdata = 8'hA5; c_addr = 16'h1000;
    tick(2);
    check("rst_stat", 32'(stat_word), 32'h0);
    check("rst_enables", 32'({o_Wr_En, o_Rd_En}), 32'h0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'h1);
    c_sys = 1'b1;
    #1;
    check("rst_system_reset", 32'(system_reset), 32'h1);
    c_sys = 1'b0;
    #1;
    spi_reset = 1'b1;
    mon_q.delete();
    tick(6);
    check("release_no_strobe", 32'(mon_q.size()), 32'h0);
    check("release_stat", 32'(stat_word), 32'h1);
    c_start = 1'b0; c_clr = 1'b0;
    tick(1);

    foreach (tbl[k]) begin
      run_cmd(tbl[k].wr, tbl[k].au, tbl[k].len, tbl[k].addr, tbl[k].wdata, tbl[k].xr, 1'b0);
      if (mon_q.size() > 0) begin
        check("tbl_first_addr", 32'(mon_q[0].a), 32'(tbl[k].e_first));
        check("tbl_last_addr", 32'(mon_q[mon_q.size()-1].a), 32'(tbl[k].e_last));
      end
      check("tbl_beats", 32'(stat_word[11:8]), 32'(tbl[k].e_beats));
    end

    // Start without CPU halted, together with clr_flags: halt_err set wins over the clear.
    c_cpu = 1'b0; c_wr = 1'b1; c_addr = 16'h5555;
    tick(1);
    mon_q.delete();
    c_start = 1'b1; c_clr = 1'b1;
    tick(4);
    check("halt_no_strobe", 32'(mon_q.size()), 32'h0);
    check("halt_flags", 32'(stat_word[5:0]), 32'h20);
    c_start = 1'b0; c_clr = 1'b0;
    tick(1);
    c_clr = 1'b1;
    tick(3);
    check("halt_cleared", 32'(stat_word[5:0]), 32'h00);
    c_clr = 1'b0; c_cpu = 1'b1;
    tick(1);

    // Second start mid-burst: overrun, original 4-beat read still completes.
    c_wr = 1'b0; c_auto = 1'b1; c_len = 4'd3; c_addr = 16'h3000; rd_xor = 8'h00;
    tick(1);
    mon_q.delete();
    c_start = 1'b1;
    tick(3);
    c_start = 1'b0;
    tick(1);
    c_start = 1'b1;
    tick(2);
    wait_idle("overrun_timeout");
    tick(1);
    for (int i = 0; i < 4; i++) mdl_buf[i] = 8'(i);
    check("overrun_strobes", 32'(mon_q.size()), 32'd4);
    check("overrun_flags", 32'(stat_word[5:0]), 32'h19);
    check("overrun_beats", 32'(stat_word[11:8]), 32'd3);
    c_start = 1'b0;
    c_sel = 4'd2;
    tick(1);
    c_clr = 1'b1;
    tick(3);
    check("overrun_cleared", 32'(stat_word[5:0]), 32'h01);
    check("overrun_rdbuf", 32'(stat_word[19:12]), 32'h02);
    c_clr = 1'b0;
    tick(1);

    // Async reset while waiting for read data.
    c_len = 4'd3; c_addr = 16'h4000; c_auto = 1'b1; c_wr = 1'b0;
    tick(1);
    c_start = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_Rd_En && n < 20);
      check("rd_strobe_seen", 32'(o_Rd_En), 32'h1);
    end
    @(posedge clk);
    #1;
    spi_reset = 1'b0;
    #1;
    check("midrst_enables", 32'({o_Wr_En, o_Rd_En}), 32'h0);
    check("midrst_stat", 32'(stat_word), 32'h0);
    check("midrst_addr", 32'(o_Address), 32'h0);
    for (int i = 0; i < 16; i++) mdl_buf[i] = 8'h00;
    tick(2);
    spi_reset = 1'b1;
    mon_q.delete();
    tick(30);
    check("midrst_no_resume", 32'(mon_q.size()), 32'h0);
    check("midrst_idle_stat", 32'(stat_word), 32'h1);
    c_start = 1'b0;
    tick(1);

    for (int r = 0; r < 12; r++)
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
